// File: rtl/asic_ioctrl_pkg.sv
// Shared types and ring bit positions for the padring control-ring sequencer.
// Imported by the sequencer and its synchronizer.
package asic_ioctrl_pkg;

    typedef enum logic [2:0] {
        S_OFF,
        S_PWRUP,
        S_RELEASE,
        S_ON,
        S_PWRDN,
        S_FAULT
    } ioctrl_state_t;

    localparam int CTRL_ISO     = 0;
    localparam int CTRL_PWR     = 1;
    localparam int CTRL_IOEN    = 2;
    localparam int CTRL_CFG_LSB = 3;

endpackage

// File: rtl/asic_ioctrl_sync.sv
// Two-flop synchronizer for the asynchronous supply-good sense.
// Both stages clear on reset so a stale "good" is never seen after reset.
module asic_ioctrl_sync
    import asic_ioctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/asic_ioctrl_seq.sv
// Padring control-ring sequencer: ordered power-up/down of the IO ring.
// Outputs are registered from the current state, so they lag the state by one cycle.
module asic_ioctrl_seq
    import asic_ioctrl_pkg::*;
#(
    parameter int NCTRL = 8,
    parameter int DLYW  = 8,
    parameter int TOUTW = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DLYW-1:0]  dly,
    input  logic [NCTRL-4:0] cfg,
    input  logic             pwr_ok,
    output logic [NCTRL-1:0] ctrlring,
    output logic             ready,
    output logic             fault
);

    ioctrl_state_t state, state_nx;

    logic [DLYW-1:0]  cnt, cnt_nx;
    logic [TOUTW-1:0] tcnt, tcnt_nx;
    logic [NCTRL-4:0] cfg_q;
    logic             ok_s;
    logic             iso_q, pwr_q, ioen_q;
    logic             iso_d, pwr_d, ioen_d, ready_d, fault_d;
    logic             step_entry;

    asic_ioctrl_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pwr_ok),
        .q     (ok_s)
    );

    always_comb begin
        state_nx = state;
        tcnt_nx  = tcnt;
        cnt_nx   = (cnt != '0) ? cnt - DLYW'(1) : cnt;
        unique case (state)
            S_OFF: begin
                if (en) state_nx = S_PWRUP;
            end
            S_PWRUP: begin
                if (!en)
                    state_nx = S_PWRDN;
                else if (cnt == '0 && ok_s)
                    state_nx = S_RELEASE;
                else if (&tcnt)
                    state_nx = S_FAULT;
                else
                    tcnt_nx = tcnt + TOUTW'(1);
            end
            S_RELEASE: begin
                if (!en)
                    state_nx = S_PWRDN;
                else if (cnt == '0)
                    state_nx = S_ON;
            end
            S_ON: begin
                if (!en) state_nx = S_PWRDN;
            end
            S_PWRDN: begin
                if (cnt == '0) state_nx = S_OFF;
            end
            S_FAULT: begin
                if (!en) state_nx = S_OFF;
            end
            default: state_nx = S_OFF;
        endcase
        // Every timed step reloads its dwell from dly on entry
        step_entry = (state_nx != state) &&
                     (state_nx inside {S_PWRUP, S_RELEASE, S_PWRDN});
        if (step_entry) cnt_nx = dly;
        if (state_nx == S_PWRUP && state != S_PWRUP) tcnt_nx = '0;
    end

    always_comb begin
        iso_d   = state inside {S_OFF, S_PWRUP, S_PWRDN, S_FAULT};
        pwr_d   = state inside {S_PWRUP, S_RELEASE, S_ON, S_PWRDN};
        ioen_d  = (state == S_ON);
        ready_d = (state == S_ON);
        fault_d = (state == S_FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_OFF;
            cnt    <= '0;
            tcnt   <= '0;
            cfg_q  <= '0;
            iso_q  <= 1'b1;
            pwr_q  <= 1'b0;
            ioen_q <= 1'b0;
            ready  <= 1'b0;
            fault  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            tcnt   <= tcnt_nx;
            if (state == S_OFF) cfg_q <= cfg;
            iso_q  <= iso_d;
            pwr_q  <= pwr_d;
            ioen_q <= ioen_d;
            ready  <= ready_d;
            fault  <= fault_d;
        end
    end

    always_comb begin
        ctrlring                           = '0;
        ctrlring[CTRL_ISO]                 = iso_q;
        ctrlring[CTRL_PWR]                 = pwr_q;
        ctrlring[CTRL_IOEN]                = ioen_q;
        ctrlring[NCTRL-1:CTRL_CFG_LSB]     = cfg_q;
    end

endmodule

// File: tb/tb_asic_ioctrl_seq.sv
// Scoreboard bench for the padring control-ring sequencer.
// dut4 uses a 16-cycle timeout; dut12 the default one for long pwr_ok waits.
module tb_asic_ioctrl_seq;

    typedef struct {
        int         cyc;
        logic [7:0] ring;
        logic       rdy;
        logic       flt;
        string      nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [7:0] dly = 8'd0;
    logic [4:0] cfg = 5'd0;
    logic       pwr_ok = 1'b0;

    logic [7:0] ring4, ring12;
    logic       rdy4, rdy12, flt4, flt12;

    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    exp_t sb[$];
    exp_t e;

    asic_ioctrl_seq #(.NCTRL(8), .DLYW(8), .TOUTW(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .dly(dly), .cfg(cfg),
        .pwr_ok(pwr_ok), .ctrlring(ring4), .ready(rdy4), .fault(flt4)
    );

    asic_ioctrl_seq #(.NCTRL(8), .DLYW(8), .TOUTW(12)) dut12 (
        .clk(clk), .reset(reset), .en(en), .dly(dly), .cfg(cfg),
        .pwr_ok(pwr_ok), .ctrlring(ring12), .ready(rdy12), .fault(flt12)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(int c, logic [7:0] r, logic rd, logic f, string nm);
        exp_t x;
        x.cyc = c; x.ring = r; x.rdy = rd; x.flt = f; x.nm = nm;
        return x;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        sb.push_back(mk(cyc, 8'h01, 1'b0, 1'b0, "reset_vals"));
        e = sb.pop_front();
        checks++;
        if ({ring4, rdy4, flt4} !== {e.ring, e.rdy, e.flt}) begin
            fails++;
            $display("FAIL %s: got ring=%h rdy=%b flt=%b, want ring=%h rdy=%b flt=%b",
                     e.nm, ring4, rdy4, flt4, e.ring, e.rdy, e.flt);
        end
        reset = 1'b0;
        cfg = 5'h1F;
        sb.push_back(mk(cyc + 1, 8'hF9, 1'b0, 1'b0, "cfg_capture_off"));
        sb.push_back(mk(cyc + 2, 8'hF9, 1'b0, 1'b0, "off_idle"));
        repeat (2) begin
            @(negedge clk);
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if ({ring4, rdy4, flt4} !== {e.ring, e.rdy, e.flt}) begin
                    fails++;
                    $display("FAIL %s: got ring=%h rdy=%b flt=%b, want ring=%h rdy=%b flt=%b",
                             e.nm, ring4, rdy4, flt4, e.ring, e.rdy, e.flt);
                end
            end
        end
    endtask

    task automatic test_powerup();
        int t;
        pwr_ok = 1'b1;
        dly = 8'd3;
        repeat (3) @(negedge clk);
        en = 1'b1;
        t = cyc + 1;
        sb.push_back(mk(t,     8'hF9, 1'b0, 1'b0, "up_t0_off"));
        sb.push_back(mk(t + 1, 8'hFB, 1'b0, 1'b0, "up_pwr_en"));
        sb.push_back(mk(t + 4, 8'hFB, 1'b0, 1'b0, "up_iso_held"));
        sb.push_back(mk(t + 5, 8'hFA, 1'b0, 1'b0, "up_iso_release"));
        sb.push_back(mk(t + 8, 8'hFA, 1'b0, 1'b0, "up_not_ready"));
        sb.push_back(mk(t + 9, 8'hFE, 1'b1, 1'b0, "up_ready"));
        sb.push_back(mk(t + 11, 8'hFE, 1'b1, 1'b0, "cfg_frozen_on"));
        repeat (12) begin
            @(negedge clk);
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if ({ring4, rdy4, flt4} !== {e.ring, e.rdy, e.flt}) begin
                    fails++;
                    $display("FAIL %s: got ring=%h rdy=%b flt=%b, want ring=%h rdy=%b flt=%b",
                             e.nm, ring4, rdy4, flt4, e.ring, e.rdy, e.flt);
                end
            end
            if (cyc == t + 9) cfg = 5'h00;
        end
    endtask

    task automatic test_powerdown();
        int u;
        dly = 8'd2;
        en = 1'b0;
        u = cyc + 1;
        sb.push_back(mk(u,     8'hFE, 1'b1, 1'b0, "dn_still_on"));
        sb.push_back(mk(u + 1, 8'hFB, 1'b0, 1'b0, "dn_io_off_iso"));
        sb.push_back(mk(u + 2, 8'hFB, 1'b0, 1'b0, "dn_en_ignored"));
        sb.push_back(mk(u + 3, 8'hFB, 1'b0, 1'b0, "dn_pwr_held"));
        sb.push_back(mk(u + 4, 8'h01, 1'b0, 1'b0, "dn_pwr_off"));
        sb.push_back(mk(u + 5, 8'h03, 1'b0, 1'b0, "dn_restart"));
        repeat (6) begin
            @(negedge clk);
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if ({ring4, rdy4, flt4} !== {e.ring, e.rdy, e.flt}) begin
                    fails++;
                    $display("FAIL %s: got ring=%h rdy=%b flt=%b, want ring=%h rdy=%b flt=%b",
                             e.nm, ring4, rdy4, flt4, e.ring, e.rdy, e.flt);
                end
            end
            if (cyc == u + 1) en = 1'b1;
        end
    endtask

    task automatic test_fault();
        int t;
        do_reset();
        cfg = 5'h00;
        pwr_ok = 1'b0;
        dly = 8'd3;
        repeat (2) @(negedge clk);
        en = 1'b1;
        t = cyc + 1;
        sb.push_back(mk(t + 1,  8'h03, 1'b0, 1'b0, "to_pwrup"));
        sb.push_back(mk(t + 16, 8'h03, 1'b0, 1'b0, "to_last_wait"));
        sb.push_back(mk(t + 17, 8'h01, 1'b0, 1'b1, "to_fault"));
        sb.push_back(mk(t + 20, 8'h01, 1'b0, 1'b1, "to_fault_hold"));
        sb.push_back(mk(t + 21, 8'h01, 1'b0, 1'b1, "to_exit_edge"));
        sb.push_back(mk(t + 22, 8'h01, 1'b0, 1'b0, "to_off_clear"));
        repeat (23) begin
            @(negedge clk);
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if ({ring4, rdy4, flt4} !== {e.ring, e.rdy, e.flt}) begin
                    fails++;
                    $display("FAIL %s: got ring=%h rdy=%b flt=%b, want ring=%h rdy=%b flt=%b",
                             e.nm, ring4, rdy4, flt4, e.ring, e.rdy, e.flt);
                end
            end
            if (cyc == t + 20) en = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int t;
        do_reset();
        cfg = 5'h00;
        pwr_ok = 1'b1;
        dly = 8'd3;
        repeat (3) @(negedge clk);
        en = 1'b1;
        t = cyc + 1;
        sb.push_back(mk(t + 6, 8'h02, 1'b0, 1'b0, "mid_release"));
        repeat (7) begin
            @(negedge clk);
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if ({ring4, rdy4, flt4} !== {e.ring, e.rdy, e.flt}) begin
                    fails++;
                    $display("FAIL %s: got ring=%h rdy=%b flt=%b, want ring=%h rdy=%b flt=%b",
                             e.nm, ring4, rdy4, flt4, e.ring, e.rdy, e.flt);
                end
            end
        end
        #2 reset = 1'b1;
        sb.push_back(mk(cyc, 8'h01, 1'b0, 1'b0, "async_reset"));
        #1;
        e = sb.pop_front();
        checks++;
        if ({ring4, rdy4, flt4} !== {e.ring, e.rdy, e.flt}) begin
            fails++;
            $display("FAIL %s: got ring=%h rdy=%b flt=%b, want ring=%h rdy=%b flt=%b",
                     e.nm, ring4, rdy4, flt4, e.ring, e.rdy, e.flt);
        end
        @(negedge clk);
        en = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_sync_latency();
        int t;
        do_reset();
        cfg = 5'h00;
        pwr_ok = 1'b0;
        dly = 8'd0;
        repeat (2) @(negedge clk);
        en = 1'b1;
        t = cyc + 1;
        sb.push_back(mk(t + 1,  8'h03, 1'b0, 1'b0, "sync_pwrup"));
        sb.push_back(mk(t + 21, 8'h03, 1'b0, 1'b0, "sync_stage1"));
        sb.push_back(mk(t + 22, 8'h03, 1'b0, 1'b0, "sync_stage2"));
        sb.push_back(mk(t + 23, 8'h02, 1'b0, 1'b0, "sync_release"));
        sb.push_back(mk(t + 24, 8'h06, 1'b1, 1'b0, "sync_on"));
        repeat (25) begin
            @(negedge clk);
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if ({ring12, rdy12, flt12} !== {e.ring, e.rdy, e.flt}) begin
                    fails++;
                    $display("FAIL %s: got ring=%h rdy=%b flt=%b, want ring=%h rdy=%b flt=%b",
                             e.nm, ring12, rdy12, flt12, e.ring, e.rdy, e.flt);
                end
            end
            if (cyc == t + 19) pwr_ok = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_powerdown();
        test_fault();
        test_reset_mid();
        test_sync_latency();
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
